// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: read-return ownership tags
// and the host starvation counter.
package dmem_pkg;

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef struct packed {
    logic   v;
    owner_t own;
  } rd_tag_t;

  // Saturating increment so a long-starved host never wraps back to "fresh".
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] x);
    return (x == WAIT_SAT) ? x : x + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side access port of the data-memory arbiter (one instance per requester).
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Delay line that carries {valid, owner} of each issued read alongside the RAM read
// latency, so the return can be steered back to the issuer.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [RD_LAT];

  // Reset empties the pipe, which drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data_ram between core and host: core priority with a
// forced host grant after MAX_WAIT lost cycles, and read-return routing to the issuer.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave h,
  output logic          core_stall,
  output logic          m_read,
  output logic          m_write,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);

  logic              c_gnt;
  logic              h_gnt;
  logic              any_gnt;
  logic              host_force;
  logic [WAIT_W-1:0] wait_cnt;

  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_din;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     din_q;

  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic              c_rvalid;
  logic              h_rvalid;
  logic [DW-1:0]     c_rdata_q;
  logic [DW-1:0]     h_rdata_q;

  assign host_force = (wait_cnt >= WAIT_W'(MAX_WAIT));

  // Grant decision: same-cycle, at most one winner.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (c.req && !host_force) begin
      c_gnt = 1'b1;
    end else if (h.req) begin
      h_gnt = 1'b1;
    end else if (c.req) begin
      c_gnt = 1'b1;
    end
  end

  assign any_gnt    = c_gnt | h_gnt;
  assign c.gnt      = c_gnt;
  assign h.gnt      = h_gnt;
  assign core_stall = c.req & ~c_gnt;

  // Host starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (h.req && !h_gnt) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= '0;
    end
  end

  // RAM-side mux from the granted requester.
  always_comb begin
    sel_we   = c.we;
    sel_addr = c.addr;
    sel_din  = c.wdata;
    if (h_gnt) begin
      sel_we   = h.we;
      sel_addr = h.addr;
      sel_din  = h.wdata;
    end
  end

  assign m_read  = any_gnt & ~sel_we;
  assign m_write = any_gnt & sel_we;
  assign m_addr  = any_gnt ? sel_addr : addr_q;
  assign m_din   = any_gnt ? sel_din  : din_q;

  // Address/data lines keep their last driven value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (any_gnt) begin
      addr_q <= sel_addr;
      din_q  <= sel_din;
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.v   = m_read;
    tag_in.own = h_gnt ? OWN_HOST : OWN_CORE;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign c_rvalid = tag_out.v && (tag_out.own == OWN_CORE);
  assign h_rvalid = tag_out.v && (tag_out.own == OWN_HOST);

  // Each owner's rdata shows the live return and then holds it until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= m_dout;
      if (h_rvalid) h_rdata_q <= m_dout;
    end
  end

  assign c.rvalid = c_rvalid;
  assign h.rvalid = h_rvalid;
  assign c.rdata  = c_rvalid ? m_dout : c_rdata_q;
  assign h.rdata  = h_rvalid ? m_dout : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT 1 and 3) share one stimulus stream and
// are compared each cycle against a transaction-level model of grants, RAM and returns.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned LAT0     = 1;
  localparam int unsigned LAT1     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_c_req = 0, s_c_we = 0, s_h_req = 0, s_h_we = 0;
  logic [7:0] s_c_addr = 0, s_c_wdata = 0, s_h_addr = 0, s_h_wdata = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) c0 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) h0 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) c1 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) h1 ();

  assign c0.req = s_c_req;  assign c0.we = s_c_we;  assign c0.addr = s_c_addr;  assign c0.wdata = s_c_wdata;
  assign h0.req = s_h_req;  assign h0.we = s_h_we;  assign h0.addr = s_h_addr;  assign h0.wdata = s_h_wdata;
  assign c1.req = s_c_req;  assign c1.we = s_c_we;  assign c1.addr = s_c_addr;  assign c1.wdata = s_c_wdata;
  assign h1.req = s_h_req;  assign h1.we = s_h_we;  assign h1.addr = s_h_addr;  assign h1.wdata = s_h_wdata;

  logic       core_stall [2];
  logic       m_read [2];
  logic       m_write [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_din [2];
  logic [7:0] m_dout [2];

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT0), .MAX_WAIT(MAX_WAIT)) dut0 (
    .clk(clk), .rst_n(rst_n), .c(c0), .h(h0), .core_stall(core_stall[0]),
    .m_read(m_read[0]), .m_write(m_write[0]), .m_addr(m_addr[0]), .m_din(m_din[0]),
    .m_dout(m_dout[0])
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .c(c1), .h(h1), .core_stall(core_stall[1]),
    .m_read(m_read[1]), .m_write(m_write[1]), .m_addr(m_addr[1]), .m_din(m_din[1]),
    .m_dout(m_dout[1])
  );

  logic       c_gnt_o [2], h_gnt_o [2], c_rv_o [2], h_rv_o [2];
  logic [7:0] c_rd_o [2], h_rd_o [2];
  assign c_gnt_o[0] = c0.gnt;    assign c_gnt_o[1] = c1.gnt;
  assign h_gnt_o[0] = h0.gnt;    assign h_gnt_o[1] = h1.gnt;
  assign c_rv_o[0]  = c0.rvalid; assign c_rv_o[1]  = c1.rvalid;
  assign h_rv_o[0]  = h0.rvalid; assign h_rv_o[1]  = h1.rvalid;
  assign c_rd_o[0]  = c0.rdata;  assign c_rd_o[1]  = c1.rdata;
  assign h_rd_o[0]  = h0.rdata;  assign h_rd_o[1]  = h1.rdata;

  // data_ram stand-ins, driven only by each DUT's m_* pins
  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic [7:0] rp0 [LAT0];
  logic [7:0] rp1 [LAT1];

  always @(posedge clk) begin
    if (m_write[0]) ram0[m_addr[0]] <= m_din[0];
    if (m_read[0])  rp0[0] <= ram0[m_addr[0]];
    for (int i = 1; i < int'(LAT0); i++) rp0[i] <= rp0[i-1];
    if (m_write[1]) ram1[m_addr[1]] <= m_din[1];
    if (m_read[1])  rp1[0] <= ram1[m_addr[1]];
    for (int i = 1; i < int'(LAT1); i++) rp1[i] <= rp1[i-1];
  end
  assign m_dout[0] = rp0[LAT0-1];
  assign m_dout[1] = rp1[LAT1-1];

  // Reference model
  typedef struct {
    int         due;
    bit         own_host;
    logic [7:0] data;
  } ret_t;

  ret_t       rq0 [$];
  ret_t       rq1 [$];
  logic [7:0] mmem [256];
  int         wc;
  int         cyc;
  logic [7:0] last_addr, last_din;
  logic [7:0] hold_c [2], hold_h [2];
  bit         c_pend, h_pend;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rq0.delete();
    rq1.delete();
    wc = 0;
    last_addr = '0;
    last_din  = '0;
    for (int k = 0; k < 2; k++) begin
      hold_c[k] = '0;
      hold_h[k] = '0;
    end
    c_pend = 0;
    h_pend = 0;
  endtask

  // Predict and compare one cycle, then advance the model past the next edge.
  task automatic eval();
    bit         frc, eg_c, eg_h, any, we, e_rd, e_wr, e_cv, e_hv;
    logic [7:0] a, d, e_ma, e_md;
    ret_t       r;
    frc  = (wc >= int'(MAX_WAIT));
    eg_c = s_c_req && (!frc || !s_h_req);
    eg_h = s_h_req && !eg_c;
    any  = eg_c || eg_h;
    we   = eg_h ? s_h_we    : s_c_we;
    a    = eg_h ? s_h_addr  : s_c_addr;
    d    = eg_h ? s_h_wdata : s_c_wdata;
    e_rd = any && !we;
    e_wr = any && we;
    e_ma = any ? a : last_addr;
    e_md = any ? d : last_din;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("c_gnt%0d", k), c_gnt_o[k], eg_c);
      check_eq($sformatf("h_gnt%0d", k), h_gnt_o[k], eg_h);
      check_eq($sformatf("core_stall%0d", k), core_stall[k], s_c_req && !eg_c);
      check_eq($sformatf("m_read%0d", k), m_read[k], e_rd);
      check_eq($sformatf("m_write%0d", k), m_write[k], e_wr);
      check_eq($sformatf("m_addr%0d", k), m_addr[k], e_ma);
      check_eq($sformatf("m_din%0d", k), m_din[k], e_md);
      e_cv = 0;
      e_hv = 0;
      if (k == 0 && rq0.size() != 0 && rq0[0].due == cyc) begin
        r = rq0.pop_front();
        if (r.own_host) begin e_hv = 1; hold_h[k] = r.data; end
        else            begin e_cv = 1; hold_c[k] = r.data; end
      end
      if (k == 1 && rq1.size() != 0 && rq1[0].due == cyc) begin
        r = rq1.pop_front();
        if (r.own_host) begin e_hv = 1; hold_h[k] = r.data; end
        else            begin e_cv = 1; hold_c[k] = r.data; end
      end
      check_eq($sformatf("c_rvalid%0d", k), c_rv_o[k], e_cv);
      check_eq($sformatf("h_rvalid%0d", k), h_rv_o[k], e_hv);
      check_eq($sformatf("c_rdata%0d", k), c_rd_o[k], hold_c[k]);
      check_eq($sformatf("h_rdata%0d", k), h_rd_o[k], hold_h[k]);
    end
    if (e_wr) mmem[a] = d;
    if (e_rd) begin
      rq0.push_back('{due: cyc + int'(LAT0), own_host: eg_h, data: mmem[a]});
      rq1.push_back('{due: cyc + int'(LAT1), own_host: eg_h, data: mmem[a]});
    end
    if (any) begin
      last_addr = a;
      last_din  = d;
    end
    if (s_h_req && !eg_h) wc = (wc >= 15) ? 15 : wc + 1;
    else                  wc = 0;
    c_pend = s_c_req && !eg_c;
    h_pend = s_h_req && !eg_h;
    cyc++;
  endtask

  // Apply one cycle of stimulus just after the edge, then check at the falling edge.
  task automatic run(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                     input bit hr, input bit hw, input logic [7:0] ha, input logic [7:0] hd);
    @(posedge clk);
    #1;
    s_c_req = cr; s_c_we = cw; s_c_addr = ca; s_c_wdata = cd;
    s_h_req = hr; s_h_we = hw; s_h_addr = ha; s_h_wdata = hd;
    @(negedge clk);
    eval();
  endtask

  task automatic idle();
    run(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_gnt%0d", k), {c_gnt_o[k], h_gnt_o[k], core_stall[k]}, 0);
      check_eq($sformatf("rst_mrw%0d", k), {m_read[k], m_write[k]}, 0);
      check_eq($sformatf("rst_maddr%0d", k), m_addr[k], 0);
      check_eq($sformatf("rst_mdin%0d", k), m_din[k], 0);
      check_eq($sformatf("rst_rvalid%0d", k), {c_rv_o[k], h_rv_o[k]}, 0);
      check_eq($sformatf("rst_rdata%0d", k), {c_rd_o[k], h_rd_o[k]}, 0);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    s_c_req = 0; s_c_we = 0; s_c_addr = 0; s_c_wdata = 0;
    s_h_req = 0; s_h_we = 0; s_h_addr = 0; s_h_wdata = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    cyc++;
    @(negedge clk);
    check_reset_outputs();
    cyc++;
    rst_n = 1'b1;
  endtask

  logic [5:0] cg_v, hg_v, st_v;
  int         cnt0, cnt1;
  bit         cr, cw, hr, hw;
  logic [7:0] ca, cd, ha, hd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = '0; ram1[i] = '0; mmem[i] = '0;
    end
    for (int i = 0; i < int'(LAT0); i++) rp0[i] = '0;
    for (int i = 0; i < int'(LAT1); i++) rp1[i] = '0;
    cyc = 0;
    apply_reset();

    // Core read of a preloaded location, single-cycle latency instance
    run(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
    run(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    check_eq("t1_gnt", c_gnt_o[0], 1);
    idle();
    check_eq("t1_rvalid", c_rv_o[0], 1);
    check_eq("t1_rdata", c_rd_o[0], 8'hA5);
    check_eq("t1_h_rvalid", h_rv_o[0], 0);
    idle(); idle(); idle();

    // Both requesting continuously: host forced through after MAX_WAIT losses
    for (int i = 0; i < 6; i++) begin
      run(1, 0, 8'(i), 8'h00, 1, 0, 8'(8'h40 + i), 8'h00);
      cg_v[i] = c_gnt_o[0];
      hg_v[i] = h_gnt_o[0];
      st_v[i] = core_stall[0];
    end
    check_eq("t2_core_gnts", cg_v, 6'b101111);
    check_eq("t2_host_gnts", hg_v, 6'b010000);
    check_eq("t2_stall", st_v, 6'b010000);
    idle(); idle(); idle();

    // Host write then core read of the same address next cycle
    run(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
    run(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    idle(); idle(); idle();
    check_eq("t3_rdata_lat1", c_rd_o[0], 8'h3C);
    check_eq("t3_rdata_lat3", c_rd_o[1], 8'h3C);
    check_eq("t3_h_rdata", h_rd_o[1], 8'h00);

    // Alternating core/host reads, pipelined returns
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) run(i % 2 == 0, 0, 8'(i), 8'h00, i % 2 == 1, 0, 8'(i), 8'h00);
      else       idle();
      cnt0 += int'(c_rv_o[0]) + int'(h_rv_o[0]);
      cnt1 += int'(c_rv_o[1]) + int'(h_rv_o[1]);
    end
    check_eq("t4_returns_lat1", cnt0, 6);
    check_eq("t4_returns_lat3", cnt1, 6);

    // Reset while reads are in flight
    run(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
    run(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
    apply_reset();
    cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      cnt0 += int'(c_rv_o[0]) + int'(h_rv_o[0]) + int'(c_rv_o[1]) + int'(h_rv_o[1]);
    end
    check_eq("t5_no_rvalid", cnt0, 0);

    // Host-only write stream: granted every cycle
    cnt0 = 0;
    for (int i = 0; i < 8; i++) begin
      run(0, 0, 8'h00, 8'h00, 1, 1, 8'(8'h80 + i), 8'($urandom));
      cnt0 += int'(h_gnt_o[0]);
    end
    check_eq("t6_host_gnts", cnt0, 8);

    // Randomized traffic with hold-until-grant requesters
    cr = 0; cw = 0; ca = 0; cd = 0; hr = 0; hw = 0; ha = 0; hd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!c_pend || $urandom_range(0, 7) == 0) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1) == 1;
        ca = 8'($urandom_range(0, 15));
        cd = 8'($urandom);
      end
      if (!h_pend || $urandom_range(0, 7) == 0) begin
        hr = ($urandom_range(0, 2) != 0);
        hw = $urandom_range(0, 1) == 1;
        ha = 8'($urandom_range(0, 15));
        hd = 8'($urandom);
      end
      run(cr, cw, ca, cd, hr, hw, ha, hd);
    end
    for (int i = 0; i < 4; i++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
